// File: rtl/stall_recovery_ctrl.sv
// stall_recovery_ctrl
//   Services stall reports from four detector channels, one at a time.
//   A stalled, non-fatal channel is granted round-robin, reported to the
//   host (srv_valid/srv_ready handshake), its detector is held in manual
//   reset for HOLD_CYCLES, the controller waits SETTLE_CYCLES, and the task
//   is restarted with a one-cycle retrigger pulse. A channel that is still
//   stalled after settling, or that has used MAX_RETRY recoveries, is
//   marked fatal until the host clears it.
//
// Parameters
//   HOLD_CYCLES    manual-reset pulse width in cycles (1..255)
//   SETTLE_CYCLES  post-clear wait in cycles (1..255)
//   MAX_RETRY      recoveries per channel before fatal (1..15)
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   ch_stall[3:0]    per-channel stall flag
//   ch_err_code[15:0] per-channel error code, channel n in [4n+3:4n]
//   ch_complete[3:0] per-channel task-complete pulse (clears retry count)
//   srv_ready        host accepts the service report
//   clr_fatal[3:0]   per-channel fatal clear pulse
//   ch_manual_reset[3:0] per-channel detector manual reset
//   ch_retrigger[3:0] per-channel one-cycle restart pulse
//   srv_valid        service report valid
//   srv_ch[1:0]      channel being serviced
//   srv_code[3:0]    error code captured at arbitration
//   fatal[3:0]       per-channel sticky fatal flag
//   irq              fatal interrupt
//
// Build option
//   STALL_RECOVERY_IRQ_EN  when defined, irq is a registered OR of fatal;
//                          otherwise irq is tied to 0.
module stall_recovery_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  ch_stall,
  input  logic [15:0] ch_err_code,
  input  logic [3:0]  ch_complete,
  input  logic        srv_ready,
  input  logic [3:0]  clr_fatal,
  output logic [3:0]  ch_manual_reset,
  output logic [3:0]  ch_retrigger,
  output logic        srv_valid,
  output logic [1:0]  srv_ch,
  output logic [3:0]  srv_code,
  output logic [3:0]  fatal,
  output logic        irq
);

  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    REPORT,
    CLEAR,
    SETTLE,
    RETRY
  } state_t;

  state_t     state;
  logic [1:0] last_grant;
  logic [7:0] cnt;
  logic [3:0] retry_cnt [4];

  logic [3:0] req;
  logic       gnt_found;
  logic [1:0] gnt_ch;
  logic [1:0] idx;
  logic       at_max;
  logic       settle_done;
  logic [3:0] srv_onehot;
  logic [3:0] fatal_set;
  logic [3:0] retry_inc;

  // Round-robin search starting one past the last grant; fatal channels
  // are excluded from the request vector.
  always_comb begin
    req       = ch_stall & ~fatal;
    gnt_found = 1'b0;
    gnt_ch    = last_grant;
    idx       = last_grant;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = idx;
      end
    end
  end

  assign at_max      = (retry_cnt[gnt_ch] == RETRY_MAX);
  assign settle_done = (state == SETTLE) && (cnt == '0);
  assign srv_onehot  = 4'b0001 << srv_ch;

  always_comb begin
    fatal_set = '0;
    retry_inc = '0;
    if (state == ARB && gnt_found && at_max) begin
      fatal_set[gnt_ch] = 1'b1;
    end
    if (settle_done && ch_stall[srv_ch]) begin
      fatal_set = fatal_set | srv_onehot;
    end
    if (state == RETRY) begin
      retry_inc = srv_onehot;
    end
  end

  // Main sequencer; all service outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= 2'd3;
      cnt             <= '0;
      ch_manual_reset <= '0;
      ch_retrigger    <= '0;
      srv_valid       <= 1'b0;
      srv_ch          <= '0;
      srv_code        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= ARB;
          end
        end
        ARB: begin
          if (!gnt_found) begin
            state <= IDLE;
          end else begin
            srv_ch     <= gnt_ch;
            srv_code   <= ch_err_code[4*gnt_ch +: 4];
            last_grant <= gnt_ch;
            if (at_max) begin
              state <= IDLE;
            end else begin
              srv_valid <= 1'b1;
              state     <= REPORT;
            end
          end
        end
        REPORT: begin
          if (srv_ready) begin
            srv_valid       <= 1'b0;
            ch_manual_reset <= srv_onehot;
            cnt             <= HOLD_LAST;
            state           <= CLEAR;
          end
        end
        CLEAR: begin
          if (cnt == '0) begin
            ch_manual_reset <= '0;
            cnt             <= SETTLE_LAST;
            state           <= SETTLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            if (ch_stall[srv_ch]) begin
              state <= IDLE;
            end else begin
              ch_retrigger <= srv_onehot;
              state        <= RETRY;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RETRY: begin
          ch_retrigger <= '0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Fatal flags and retry counters. A fatal set beats a same-cycle clear;
  // ch_complete clears the count regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fatal <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        retry_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (fatal_set[i]) begin
          fatal[i] <= 1'b1;
        end else if (clr_fatal[i]) begin
          fatal[i] <= 1'b0;
        end
        if (ch_complete[i] || (clr_fatal[i] && !fatal_set[i])) begin
          retry_cnt[i] <= '0;
        end else if (retry_inc[i] && retry_cnt[i] < RETRY_MAX) begin
          retry_cnt[i] <= retry_cnt[i] + 4'd1;
        end
      end
    end
  end

`ifdef STALL_RECOVERY_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |fatal;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_stall_recovery_ctrl.sv
// Self-checking bench for stall_recovery_ctrl. A behavioural model tracks
// last grant, retry counts and fatal flags; a host/detector driver task
// collects what the DUT did during one service, and each test task compares
// those observations against model predictions.
module tb_stall_recovery_ctrl;

  localparam int HOLD   = 4;
  localparam int SETTLE = 8;
  localparam int MAXR   = 3;
`ifdef STALL_RECOVERY_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ch_stall = '0;
  logic [15:0] ch_err_code = '0;
  logic [3:0]  ch_complete = '0;
  logic        srv_ready = 1'b0;
  logic [3:0]  clr_fatal = '0;
  logic [3:0]  ch_manual_reset;
  logic [3:0]  ch_retrigger;
  logic        srv_valid;
  logic [1:0]  srv_ch;
  logic [3:0]  srv_code;
  logic [3:0]  fatal;
  logic        irq;

  stall_recovery_ctrl #(
    .HOLD_CYCLES  (HOLD),
    .SETTLE_CYCLES(SETTLE),
    .MAX_RETRY    (MAXR)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ch_stall       (ch_stall),
    .ch_err_code    (ch_err_code),
    .ch_complete    (ch_complete),
    .srv_ready      (srv_ready),
    .clr_fatal      (clr_fatal),
    .ch_manual_reset(ch_manual_reset),
    .ch_retrigger   (ch_retrigger),
    .srv_valid      (srv_valid),
    .srv_ch         (srv_ch),
    .srv_code       (srv_code),
    .fatal          (fatal),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_last = 3;
  logic [3:0] m_fatal = '0;
  int         m_retry [4] = '{0, 0, 0, 0};

  typedef struct {
    bit         got;
    int         ch;
    logic [3:0] code;
    logic [3:0] mr_pat;
    int         mr_w;
    int         gap;
    logic [3:0] rt_pat;
    int         rt_w;
    bit         stable;
    bit         early;
    bit         mr_bad;
    bit         fatal_end;
    bit         timeout;
  } obs_t;

  function automatic int rr_pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_after(input int ch, input bit got, input bit keep);
    m_last = ch;
    if (!got || keep) m_fatal[ch] = 1'b1;
    else if (m_retry[ch] < MAXR) m_retry[ch] = m_retry[ch] + 1;
  endtask

  task automatic model_reset();
    m_last  = 3;
    m_fatal = '0;
    for (int i = 0; i < 4; i++) m_retry[i] = 0;
  endtask

  task automatic clear_all();
    @(negedge clk);
    clr_fatal   = 4'hF;
    ch_complete = 4'hF;
    @(negedge clk);
    clr_fatal   = '0;
    ch_complete = '0;
    @(negedge clk);
    m_fatal = '0;
    for (int i = 0; i < 4; i++) m_retry[i] = 0;
  endtask

  // Plays host and detector for one service and records what happened.
  // Called at a negedge; returns at a negedge with the FSM idle.
  task automatic run_service(input int rw, input bit keep, output obs_t o);
    int n;
    logic [3:0] f0;
    o.got = 0; o.ch = 0; o.code = '0; o.mr_pat = '0; o.mr_w = 0; o.gap = 0;
    o.rt_pat = '0; o.rt_w = 0; o.stable = 1; o.early = 0; o.mr_bad = 0;
    o.fatal_end = 0; o.timeout = 0;
    f0 = fatal;
    n  = 0;
    while (!srv_valid && fatal == f0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!srv_valid) begin
      o.timeout = (fatal == f0);
      return;
    end
    o.got  = 1;
    o.ch   = int'(srv_ch);
    o.code = srv_code;
    for (int i = 0; i < rw; i++) begin
      @(negedge clk);
      if (!srv_valid || int'(srv_ch) != o.ch || srv_code !== o.code) o.stable = 0;
      if (ch_manual_reset != 4'b0) o.early = 1;
    end
    srv_ready = 1'b1;
    @(negedge clk);
    srv_ready = 1'b0;
    o.mr_pat = ch_manual_reset;
    if (!keep) ch_stall[o.ch] = 1'b0;
    n = 0;
    while (ch_manual_reset != 4'b0 && n < 300) begin
      if (ch_manual_reset !== o.mr_pat) o.mr_bad = 1;
      n++;
      @(negedge clk);
    end
    o.mr_w = n;
    if (n >= 300) o.timeout = 1;
    n = 0;
    while (ch_retrigger == 4'b0 && !fatal[o.ch] && n < 300) begin
      if (ch_manual_reset != 4'b0) o.mr_bad = 1;
      n++;
      @(negedge clk);
    end
    if (n >= 300) o.timeout = 1;
    o.gap       = n;
    o.fatal_end = fatal[o.ch];
    o.rt_pat    = ch_retrigger;
    if (ch_retrigger != 4'b0) begin
      @(negedge clk);
      o.rt_w = (ch_retrigger != 4'b0) ? 2 : 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ch_manual_reset, ch_retrigger, srv_valid, srv_ch, srv_code, fatal, irq} !== 20'b0) begin
      errors++;
      $display("FAIL reset_outputs: got mr=%b rt=%b v=%b ch=%0d code=%h fatal=%b irq=%b, want all 0",
               ch_manual_reset, ch_retrigger, srv_valid, srv_ch, srv_code, fatal, irq);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (srv_valid !== 1'b0 || ch_manual_reset !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got valid=%b mr=%b, want 0/0000", srv_valid, ch_manual_reset);
    end
    model_reset();
  endtask

  task automatic test_round_robin();
    obs_t o;
    int exp;
    ch_err_code = 16'($urandom);
    ch_stall    = 4'hF;
    for (int k = 0; k < 4; k++) begin
      exp = rr_pick(ch_stall & ~m_fatal);
      run_service(0, 1'b0, o);
      checks++;
      if (!o.got || o.ch != exp || exp != k) begin
        errors++;
        $display("FAIL rr_grant_%0d: got ch=%0d (report=%0d), want %0d", k, o.ch, o.got, k);
      end
      checks++;
      if (o.code !== ch_err_code[4*k +: 4] || o.rt_pat !== (4'b0001 << k)) begin
        errors++;
        $display("FAIL rr_service_%0d: got code=%h retrig=%b, want %h %b", k, o.code, o.rt_pat,
                 ch_err_code[4*k +: 4], 4'b0001 << k);
      end
      model_after(exp, 1'b1, 1'b0);
    end
    ch_stall = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    obs_t o;
    int exp;
    clear_all();
    ch_err_code        = 16'($urandom);
    ch_err_code[11:8]  = 4'h1;
    srv_ready          = 1'b1;
    ch_stall           = 4'b0100;
    exp = rr_pick(ch_stall & ~m_fatal);
    run_service(0, 1'b0, o);
    ch_stall = '0;
    checks++;
    if (!o.got || o.ch != 2 || exp != 2 || o.code !== 4'h1) begin
      errors++;
      $display("FAIL single_report: got report=%0d ch=%0d code=%h, want 1 2 1", o.got, o.ch, o.code);
    end
    checks++;
    if (o.mr_pat !== 4'b0100 || o.mr_w != HOLD || o.mr_bad) begin
      errors++;
      $display("FAIL single_clear: got mr=%b width=%0d bad=%0d, want 0100 width %0d", o.mr_pat, o.mr_w,
               o.mr_bad, HOLD);
    end
    checks++;
    if (o.gap != SETTLE || o.rt_pat !== 4'b0100 || o.rt_w != 1) begin
      errors++;
      $display("FAIL single_settle_retrig: got gap=%0d retrig=%b width=%0d, want %0d 0100 1", o.gap,
               o.rt_pat, o.rt_w, SETTLE);
    end
    model_after(2, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fatal_retry();
    obs_t o;
    int exp;
    bit exp_rep;
    clear_all();
    for (int k = 0; k < 4; k++) begin
      ch_err_code = 16'($urandom);
      ch_stall    = 4'b0010;
      exp         = rr_pick(ch_stall & ~m_fatal);
      exp_rep     = (m_retry[exp] < MAXR);
      run_service($urandom_range(0, 2), 1'b0, o);
      ch_stall = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (o.got != exp_rep || o.timeout || (exp_rep && o.rt_pat !== 4'b0010)) begin
        errors++;
        $display("FAIL retry_round_%0d: got report=%0d retrig=%b timeout=%0d, want report=%0d", k,
                 o.got, o.rt_pat, o.timeout, exp_rep);
      end
      model_after(exp, exp_rep, 1'b0);
    end
    checks++;
    if (fatal !== 4'b0010 || fatal !== m_fatal) begin
      errors++;
      $display("FAIL retry_fatal: got fatal=%b, want 0010", fatal);
    end
    checks++;
    if (irq !== IRQ_EN) begin
      errors++;
      $display("FAIL retry_irq: got irq=%b, want %b", irq, IRQ_EN);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    clear_all();
    ch_err_code = 16'($urandom);
    ch_stall    = 4'b1000;
    run_service(10, 1'b0, o);
    ch_stall = '0;
    checks++;
    if (!o.got || !o.stable || o.early || o.ch != 3 || o.code !== ch_err_code[15:12]) begin
      errors++;
      $display("FAIL backpressure_hold: got report=%0d stable=%0d early_mr=%0d ch=%0d code=%h", o.got,
               o.stable, o.early, o.ch, o.code);
    end
    checks++;
    if (o.mr_pat !== 4'b1000 || o.mr_w != HOLD) begin
      errors++;
      $display("FAIL backpressure_clear: got mr=%b width=%0d, want 1000 %0d", o.mr_pat, o.mr_w, HOLD);
    end
    model_after(3, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_settle_fatal();
    obs_t o;
    clear_all();
    ch_err_code = 16'($urandom);
    ch_stall    = 4'b0001;
    run_service(1, 1'b1, o);
    checks++;
    if (!o.got || o.ch != 0 || !o.fatal_end || o.rt_pat !== 4'b0 || o.gap != SETTLE) begin
      errors++;
      $display("FAIL settle_fatal: got report=%0d ch=%0d fatal=%0d retrig=%b gap=%0d", o.got, o.ch,
               o.fatal_end, o.rt_pat, o.gap);
    end
    model_after(0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (fatal !== 4'b0001 || irq !== IRQ_EN || srv_valid !== 1'b0) begin
      errors++;
      $display("FAIL settle_fatal_hold: got fatal=%b irq=%b valid=%b", fatal, irq, srv_valid);
    end
    clr_fatal = 4'b0001;
    @(negedge clk);
    clr_fatal   = '0;
    m_fatal[0]  = 1'b0;
    m_retry[0]  = 0;
    checks++;
    if (fatal[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_fatal: got fatal=%b, want bit0 clear", fatal);
    end
    run_service(0, 1'b0, o);
    ch_stall = '0;
    checks++;
    if (!o.got || o.ch != 0 || o.rt_pat !== 4'b0001) begin
      errors++;
      $display("FAIL reservice_ch0: got report=%0d ch=%0d retrig=%b", o.got, o.ch, o.rt_pat);
    end
    model_after(0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    obs_t o;
    int exp;
    bit exp_rep;
    bit keep;
    logic [3:0] m;
    logic [3:0] oh;
    clear_all();
    for (int it = 0; it < 24; it++) begin
      ch_stall = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (fatal !== m_fatal || irq !== (IRQ_EN & (|m_fatal))) begin
        errors++;
        $display("FAIL rand_fatal_%0d: got fatal=%b irq=%b, want %b %b", it, fatal, irq, m_fatal,
                 IRQ_EN & (|m_fatal));
      end
      if ($urandom_range(0, 2) == 0) begin
        m = 4'($urandom);
        ch_complete = m;
        @(negedge clk);
        ch_complete = '0;
        for (int i = 0; i < 4; i++) if (m[i]) m_retry[i] = 0;
      end
      if (m_fatal == 4'hF || (m_fatal != 0 && $urandom_range(0, 3) == 0)) begin
        m = 4'($urandom) | (m_fatal == 4'hF ? 4'b0001 : 4'b0000);
        clr_fatal = m;
        @(negedge clk);
        clr_fatal = '0;
        m_fatal   = m_fatal & ~m;
        for (int i = 0; i < 4; i++) if (m[i]) m_retry[i] = 0;
        @(negedge clk);
      end
      m = 4'($urandom_range(1, 15));
      while ((m & ~m_fatal) == 4'b0) m = 4'($urandom_range(1, 15));
      ch_err_code = 16'($urandom);
      keep    = ($urandom_range(0, 7) == 0);
      exp     = rr_pick(m & ~m_fatal);
      exp_rep = (m_retry[exp] < MAXR);
      oh      = 4'b0001 << exp;
      ch_stall = m;
      run_service($urandom_range(0, 4), keep, o);
      ch_stall = '0;
      checks++;
      if (o.got != exp_rep || o.timeout || (o.got && (o.ch != exp || o.code !== ch_err_code[4*exp +: 4]))) begin
        errors++;
        $display("FAIL rand_report_%0d: got report=%0d ch=%0d code=%h timeout=%0d, want %0d %0d %h", it,
                 o.got, o.ch, o.code, o.timeout, exp_rep, exp, ch_err_code[4*exp +: 4]);
      end
      if (exp_rep) begin
        checks++;
        if (o.mr_pat !== oh || o.mr_w != HOLD || o.mr_bad || o.gap != SETTLE) begin
          errors++;
          $display("FAIL rand_clear_%0d: got mr=%b width=%0d bad=%0d gap=%0d, want %b %0d 0 %0d", it,
                   o.mr_pat, o.mr_w, o.mr_bad, o.gap, oh, HOLD, SETTLE);
        end
        checks++;
        if (keep ? (o.rt_pat !== 4'b0 || !o.fatal_end) : (o.rt_pat !== oh || o.rt_w != 1 || o.fatal_end)) begin
          errors++;
          $display("FAIL rand_outcome_%0d: got retrig=%b width=%0d fatal=%0d, keep_stall=%0d", it,
                   o.rt_pat, o.rt_w, o.fatal_end, keep);
        end
      end
      model_after(exp, exp_rep, keep);
    end
    ch_stall = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    obs_t o;
    int n;
    clear_all();
    ch_err_code = 16'($urandom);
    ch_stall    = 4'b0010;
    n = 0;
    while (!srv_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (srv_valid !== 1'b1) begin
      errors++;
      $display("FAIL midclr_report: got valid=%b after %0d cycles, want 1", srv_valid, n);
    end
    srv_ready = 1'b1;
    @(negedge clk);
    srv_ready = 1'b0;
    checks++;
    if (ch_manual_reset !== 4'b0010) begin
      errors++;
      $display("FAIL midclr_cycle1: got mr=%b, want 0010", ch_manual_reset);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ch_manual_reset, ch_retrigger, srv_valid, srv_ch, srv_code, fatal, irq} !== 20'b0) begin
      errors++;
      $display("FAIL midclr_async: got mr=%b rt=%b v=%b ch=%0d code=%h fatal=%b irq=%b, want all 0",
               ch_manual_reset, ch_retrigger, srv_valid, srv_ch, srv_code, fatal, irq);
    end
    ch_stall = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (srv_valid !== 1'b0 || ch_manual_reset !== 4'b0) begin
      errors++;
      $display("FAIL midclr_idle: got valid=%b mr=%b, want 0/0000", srv_valid, ch_manual_reset);
    end
    ch_stall = 4'b1001;
    run_service(0, 1'b0, o);
    ch_stall = '0;
    checks++;
    if (!o.got || o.ch != rr_pick(4'b1001) || o.ch != 0) begin
      errors++;
      $display("FAIL midclr_first_grant: got report=%0d ch=%0d, want 1 0", o.got, o.ch);
    end
    model_after(0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_fatal_retry();
    test_settle_fatal();
    test_random();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
